// File: rtl/uart_tx_if.sv
// ============================================================================
// Module   : uart_tx_if
// Purpose  : Byte handshake between a controller and the UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_ready;

  modport master (output tx_data, output tx_en, input tx_ready);
  modport slave  (input tx_data, input tx_en, output tx_ready);
endinterface

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Purpose  : 8N1 UART serializer, BAUD_THRESHOLD clk cycles per bit.
//            Define UART_PARITY_EN to insert an even-parity bit before STOP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int BAUD_THRESHOLD = 434
) (
  input  wire logic        clk,
  input  wire logic        rst,
  uart_tx_if.slave         bus,
  output logic             tx,
  output logic [10:0]      ctr,
  output logic [4:0]       stage
);

  localparam logic [10:0] LAST_CTR = 11'(BAUD_THRESHOLD - 1);

  typedef enum logic [4:0] {
    IDLE   = 5'd0,
    START  = 5'd1,
    DATA0  = 5'd2,
    DATA1  = 5'd3,
    DATA2  = 5'd4,
    DATA3  = 5'd5,
    DATA4  = 5'd6,
    DATA5  = 5'd7,
    DATA6  = 5'd8,
    DATA7  = 5'd9,
    STOP   = 5'd10,
    PARITY = 5'd11
  } stage_t;

  stage_t      state, next_state;
  logic [10:0] next_ctr;
  logic [7:0]  shift_reg, next_shift;
  logic        next_tx;
  logic        ready, next_ready;
`ifdef UART_PARITY_EN
  logic        parity, next_parity;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ctr       <= 11'd0;
      shift_reg <= 8'd0;
      tx        <= 1'b1;
      ready     <= 1'b1;
`ifdef UART_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      state     <= next_state;
      ctr       <= next_ctr;
      shift_reg <= next_shift;
      tx        <= next_tx;
      ready     <= next_ready;
`ifdef UART_PARITY_EN
      parity    <= next_parity;
`endif
    end
  end

  // tx is computed one cycle ahead so the pin comes straight from a flop.
  always_comb begin
    next_state = state;
    next_ctr   = ctr;
    next_shift = shift_reg;
    next_tx    = tx;
    next_ready = ready;
`ifdef UART_PARITY_EN
    next_parity = parity;
`endif
    if (state == IDLE) begin
      next_ctr   = 11'd0;
      next_tx    = 1'b1;
      next_ready = 1'b1;
      if (bus.tx_en) begin
        next_shift = bus.tx_data;
        next_state = START;
        next_tx    = 1'b0;
        next_ready = 1'b0;
`ifdef UART_PARITY_EN
        next_parity = ^bus.tx_data;
`endif
      end
    end else if (ctr == LAST_CTR) begin
      next_ctr = 11'd0;
      case (state)
        START, DATA0, DATA1, DATA2, DATA3, DATA4, DATA5, DATA6: begin
          next_state = stage_t'(state + 5'd1);
          next_tx    = shift_reg[0];
          next_shift = {1'b0, shift_reg[7:1]};
        end
        DATA7: begin
`ifdef UART_PARITY_EN
          next_state = PARITY;
          next_tx    = parity;
`else
          next_state = STOP;
          next_tx    = 1'b1;
`endif
        end
        PARITY: begin
          next_state = STOP;
          next_tx    = 1'b1;
        end
        STOP: begin
          next_state = IDLE;
          next_tx    = 1'b1;
          next_ready = 1'b1;
        end
        default: begin
          next_state = IDLE;
          next_tx    = 1'b1;
          next_ready = 1'b1;
        end
      endcase
    end else begin
      next_ctr = ctr + 11'd1;
    end
  end

  assign bus.tx_ready = ready;
  assign stage        = state;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Directed self-checking bench for uart_tx at BAUD_THRESHOLD=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  localparam int B = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx;
  logic [10:0] ctr;
  logic [4:0]  stage;
  int          n_tests = 0;
  int          n_fail  = 0;

  uart_tx_if bus ();

  uart_tx #(.BAUD_THRESHOLD(B)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .tx    (tx),
    .ctr   (ctr),
    .stage (stage)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered with stage=1/ctr=0 visible; leaves on the idle cycle after STOP.
  task automatic run_frame(input string name, input logic [7:0] b, input int poke_cyc,
                           input logic [7:0] poke_data, input logic poke_en);
    logic [4:0] seq [11];
    logic       ebit [11];
    int         nst;
    int         idx;
    int         busy;
    seq[0] = 5'd1;
    ebit[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      seq[k+1]  = 5'(2 + k);
      ebit[k+1] = b[k];
    end
    idx = 9;
`ifdef UART_PARITY_EN
    seq[idx]  = 5'd11;
    ebit[idx] = ^b;
    idx++;
`endif
    seq[idx]  = 5'd10;
    ebit[idx] = 1'b1;
    nst  = idx + 1;
    busy = 0;
    for (int s = 0; s < nst; s++) begin
      for (int c = 0; c < B; c++) begin
        check($sformatf("%s s%0d c%0d stage", name, s, c), 32'(stage), 32'(seq[s]));
        check($sformatf("%s s%0d c%0d ctr", name, s, c), 32'(ctr), 32'(c));
        check($sformatf("%s s%0d c%0d tx", name, s, c), 32'(tx), 32'(ebit[s]));
        if (!bus.tx_ready) busy++;
        if (s * B + c == poke_cyc) begin
          bus.tx_data = poke_data;
          bus.tx_en   = poke_en;
        end
        tick();
      end
    end
    check({name, " frame length"}, 32'(busy), 32'(nst * B));
    check({name, " end stage"}, 32'(stage), 32'd0);
    check({name, " end ready"}, 32'(bus.tx_ready), 32'd1);
    check({name, " end tx"}, 32'(tx), 32'd1);
    check({name, " end ctr"}, 32'(ctr), 32'd0);
  endtask

  initial begin
    bus.tx_data = 8'h00;
    bus.tx_en   = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("reset tx", 32'(tx), 32'd1);
    check("reset ready", 32'(bus.tx_ready), 32'd1);
    check("reset ctr", 32'(ctr), 32'd0);
    check("reset stage", 32'(stage), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("idle hold stage", 32'(stage), 32'd0);
    check("idle hold ctr", 32'(ctr), 32'd0);

    // First frame: data changes mid-frame, tx_en held for back-to-back.
    bus.tx_data = 8'h55;
    bus.tx_en   = 1'b1;
    tick();
    check("f55 start ready", 32'(bus.tx_ready), 32'd0);
    run_frame("f55", 8'h55, 10, 8'h0F, 1'b1);

    // One idle cycle, then the next frame starts with the new byte.
    tick();
    run_frame("f0F", 8'h0F, 18, 8'h0F, 1'b0);
    tick();
    check("post f0F idle stage", 32'(stage), 32'd0);
    check("post f0F idle ready", 32'(bus.tx_ready), 32'd1);

    bus.tx_data = 8'h07;
    bus.tx_en   = 1'b1;
    tick();
    bus.tx_en   = 1'b0;
    run_frame("f07", 8'h07, -1, 8'h07, 1'b0);

    // Reset in the middle of DATA bit 0 of 0xAA (line low there).
    bus.tx_data = 8'hAA;
    bus.tx_en   = 1'b1;
    tick();
    bus.tx_en   = 1'b0;
    repeat (B + 1) tick();
    check("pre-rst stage", 32'(stage), 32'd2);
    check("pre-rst tx", 32'(tx), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("async rst tx", 32'(tx), 32'd1);
    check("async rst ready", 32'(bus.tx_ready), 32'd1);
    check("async rst stage", 32'(stage), 32'd0);
    check("async rst ctr", 32'(ctr), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("after rst idle", 32'(stage), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
